// File: rtl/sdram_arbiter.sv
// Two-client arbiter in front of a single-command SDRAM controller; at most one transaction in flight.
// Define SDRAM_ARBITER_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise client 0 has fixed priority.
module sdram_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  c0_command,
    input  logic [21:0] c0_address,
    input  logic [15:0] c0_data_write,
    output logic        c0_ack,
    output logic [15:0] c0_data_read,
    input  logic [1:0]  c1_command,
    input  logic [21:0] c1_address,
    input  logic [15:0] c1_data_write,
    output logic        c1_ack,
    output logic [15:0] c1_data_read,
    output logic [1:0]  command,
    output logic [21:0] data_address,
    output logic [15:0] data_write,
    input  logic [15:0] data_read,
    input  logic        data_ready,
    input  logic        data_next
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_READ = 2'd2
    } state_t;

    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;

    state_t      state;
    state_t      state_next;
    logic        grant;        // 0 = client 0 owns the current transaction
    logic        grant_next;
    logic [1:0]  command_next;
    logic [21:0] address_next;
    logic [15:0] wdata_next;
    logic        c0_req;
    logic        c1_req;
    logic        pick;
    logic        ack_any;
    logic        read_done;

    // Commands 0 (idle) and 3 (reserved) never count as a request.
    assign c0_req = (c0_command == CMD_WRITE) || (c0_command == CMD_READ);
    assign c1_req = (c1_command == CMD_WRITE) || (c1_command == CMD_READ);

`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
    logic last;
    logic last_next;

    // On a tie the client that was not granted last wins.
    always_comb begin
        if (c0_req && c1_req) begin
            pick = ~last;
        end else begin
            pick = ~c0_req;
        end
    end

    always_comb begin
        last_next = last;
        if ((state == IDLE) && (c0_req || c1_req)) begin
            last_next = pick;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last <= 1'b1;
        end else begin
            last <= last_next;
        end
    end
`else
    always_comb begin
        pick = ~c0_req;
    end
`endif

    always_comb begin
        state_next   = state;
        grant_next   = grant;
        command_next = command;
        address_next = data_address;
        wdata_next   = data_write;
        ack_any      = 1'b0;
        read_done    = 1'b0;
        case (state)
            IDLE: begin
                if (c0_req || c1_req) begin
                    grant_next   = pick;
                    command_next = pick ? c1_command    : c0_command;
                    address_next = pick ? c1_address    : c0_address;
                    wdata_next   = pick ? c1_data_write : c0_data_write;
                    state_next   = ISSUE;
                end
            end
            ISSUE: begin
                // data_ready is deliberately not looked at here, even on a read.
                if (data_next) begin
                    command_next = CMD_IDLE;
                    if (command == CMD_WRITE) begin
                        ack_any    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = WAIT_READ;
                    end
                end
            end
            WAIT_READ: begin
                if (data_ready) begin
                    ack_any    = 1'b1;
                    read_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            grant        <= 1'b0;
            command      <= CMD_IDLE;
            data_address <= '0;
            data_write   <= '0;
        end else begin
            state        <= state_next;
            grant        <= grant_next;
            command      <= command_next;
            data_address <= address_next;
            data_write   <= wdata_next;
        end
    end

    // Reset forces IDLE asynchronously, so these strobes drop to 0 with it.
    assign c0_ack       = ack_any & ~grant;
    assign c1_ack       = ack_any &  grant;
    assign c0_data_read = (read_done && !grant) ? data_read : 16'h0000;
    assign c1_data_read = (read_done &&  grant) ? data_read : 16'h0000;

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 The block SHALL have exactly one clock, `clk`, and its reset SHALL be asynchronous and active-low, `reset_n`.
REQ-002 Ports SHALL be as follows (clock and reset first):
- `clk`  in  1  system clock, same clock as the SDRAM controller.
- `reset_n`  in  1  asynchronous active-low reset.
- `c0_command`, `c1_command`  in  2 each  client command: 0 idle, 1 write, 2 read, 3 reserved.
- `c0_address`, `c1_address`  in  22 each  client word address.
- `c0_data_write`, `c1_data_write`  in  16 each  client write data.
- `c0_ack`, `c1_ack`  out  1 each  one-cycle transaction-complete strobe.
- `c0_data_read`, `c1_data_read`  out  16 each  read data, valid only while the matching ack is high on a read.
- `command`  out  2  command to the controller.
- `data_address`  out  22  address to the controller.
- `data_write`  out  16  write data to the controller.
- `data_read`  in  16  read data from the controller.
- `data_ready`  in  1  controller read data valid.
- `data_next`  in  1  controller accepted the current command.

Function
REQ-003 The block SHALL arbitrate two clients onto one controller and SHALL allow at most one transaction in flight.
REQ-004 The state machine SHALL have three states:
- IDLE: no client granted.
- ISSUE: command driven and held until the controller accepts it.
- WAIT_READ: read accepted, waiting for data.
REQ-005 In IDLE, a client SHALL count as requesting when its command is 1 or 2; command 0 and command 3 SHALL be ignored.
REQ-006 In IDLE with at least one client requesting, at the clock edge the block SHALL:
- latch the grant;
- register that client's command, address and write data onto `command`, `data_address` and `data_write`;
- enter ISSUE.
The command SHALL be visible on the cycle after the request was sampled.
REQ-007 In ISSUE, `command`, `data_address` and `data_write` SHALL be held stable until `data_next` is sampled high.
REQ-008 In ISSUE, when `data_next` is high on a write, the block SHALL:
- assert the granted client's ack combinationally in that same cycle;
- register `command` to 0;
- return to IDLE.
REQ-009 In ISSUE, when `data_next` is high on a read, the block SHALL register `command` to 0 and enter WAIT_READ, with no ack yet.
REQ-010 In WAIT_READ, when `data_ready` is high, the block SHALL:
- assert the granted client's ack combinationally;
- drive `data_read` onto that client's data_read in that same cycle;
- return to IDLE.
REQ-011 A client SHALL hold its command, address and data until its ack; a client may issue a new command on the cycle after its ack.
REQ-012 The minimum gap between back-to-back transactions SHALL be one IDLE cycle.
REQ-013 `data_next` SHALL be ignored outside ISSUE, and `data_ready` SHALL be ignored outside WAIT_READ.
REQ-014 The ack of the non-granted client SHALL be 0 at all times.
REQ-015 Each client's data_read output SHALL be 0 whenever its ack is low.
REQ-016 If both `data_next` and `data_ready` are high in ISSUE on a read, `data_ready` SHALL be ignored and the block SHALL enter WAIT_READ.
REQ-017 The block SHALL record the last-granted client in a 1-bit register, updated at every grant.

Reset
REQ-018 While `reset_n` is low, the block SHALL asynchronously force:
- state to IDLE;
- `command` to 0;
- `data_address` and `data_write` to 0;
- last-granted to client 1, so that client 0 wins the first round-robin tie.
REQ-019 The ack outputs and data_read outputs SHALL evaluate to 0 during reset.
REQ-020 A reset asserted mid-transaction SHALL abandon the transaction with no ack to either client.

Configuration
REQ-021 With `SDRAM_ARBITER_ROUND_ROBIN_EN` defined, when both clients request in IDLE, the grant SHALL go to the client not granted last.
REQ-022 Without `SDRAM_ARBITER_ROUND_ROBIN_EN`, client 0 SHALL always win when both clients request, and the last-granted register may be omitted.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Write: c0 command=1, address 0x00123, data 0xFACE; `data_next` 3 cycles later → `command`=1, `data_address`=0x00123, `data_write`=0xFACE held for 3 cycles; c0_ack high for 1 cycle with `data_next`; `command`=0 on the next cycle.
- Read: c1 command=2, address 0x3FFFFF; `data_next`, then `data_ready` 4 cycles later with `data_read`=0xBEEF → c1_ack high for 1 cycle with c1_data_read=0xBEEF; c0_ack stays 0.
- Contention with ROUND_ROBIN_EN: both clients request continuously from reset → grant order c0, c1, c0, c1. Without the macro → c0, c0, c0.
- Spurious strobes: `data_ready` pulsed in IDLE and `data_next` pulsed in WAIT_READ → no ack and no state change.
- Reserved command: c0 command=3 → `command` stays 0 and no grant.
- Reset mid-read: `reset_n` low during WAIT_READ → `command`=0 immediately; no ack; a new write after reset completes normally.
